sh1_ifetch: RTL and testbench
=============================

SH1_IFETCH -- requirements
Module: sh1_ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter IFQ_DEPTH, default 4, halfword queue depth (power of 2, >=4).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port imem_req  output  1  fetch request valid.
REQ-006 SHALL have port imem_addr  output  32  fetch address, bits[1:0]=0.
REQ-007 SHALL have port imem_gnt  input  1  request accepted this cycle when high with imem_req.
REQ-008 SHALL have port imem_rvalid  input  1  response data valid, at least 1 cycle after grant.
REQ-009 SHALL have port imem_rdata  input  32  big-endian word, [31:16] = lower address.
REQ-010 SHALL have port instr_valid  output  1  opcode offered to decoder.
REQ-011 SHALL have port instr_ready  input  1  decoder accepts when high with instr_valid.
REQ-012 SHALL have port instr  output  16  SH-1 opcode.
REQ-013 SHALL have port instr_pc  output  32  address of instr, bit0=0.
REQ-014 SHALL have port redirect_valid  input  1  branch/exception redirect strobe.
REQ-015 SHALL have port redirect_pc  input  32  new PC; bit0 ignored.

Function
REQ-016 SHALL keep at most one outstanding memory request.
REQ-017 SHALL use states IDLE, REQ, WAIT_RSP, DISCARD (enum in package).
REQ-018 IDLE->REQ when queue free slots, minus slots reserved, >=2 and no redirect; REQ holds imem_req=1, imem_addr stable until imem_gnt; REQ->WAIT_RSP on grant.
REQ-019 WAIT_RSP on imem_rvalid: enqueue [31:16] if fetch_pc[1]=0, then [15:0]; fetch_pc <= word address + 4; ->IDLE (or REQ if space, back-to-back).
REQ-020 Fetch starting at fetch_pc[1]=1 SHALL enqueue only [15:0] with instr_pc = fetch_pc.
REQ-021 Each queued entry SHALL carry its own 32-bit PC; instr_pc increments by 2 per entry, wrapping modulo 2^32.
REQ-022 Enqueued halfword SHALL appear on instr_valid the cycle after imem_rvalid (one-cycle latency); dequeue on instr_valid&&instr_ready.
REQ-023 instr/instr_pc SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-024 Simultaneous enqueue and dequeue SHALL both take effect; never overflow, never underflow.
REQ-025 redirect_valid SHALL take priority over all events in that cycle: queue flushed, instr_valid=0 next cycle, fetch_pc <= {redirect_pc[31:1],1'b0}.
REQ-026 Redirect in REQ SHALL drop the pending request and re-issue at new address next cycle (imem_addr may change only after redirect).
REQ-027 Redirect in WAIT_RSP SHALL go to DISCARD; stale response dropped; then REQ with new address.
REQ-028 Redirect in same cycle as imem_rvalid SHALL drop that response data.
REQ-029 Dequeue handshake in redirect cycle SHALL count as accepted by decoder.

Reset
REQ-030 On rst_n low (asynchronous): imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, queue empty, state IDLE, fetch_pc=RESET_PC.
REQ-031 First imem_req SHALL assert in the first clock cycle after rst_n deasserts; reset mid-transaction abandons it, any later rvalid for it ignored until first new grant.

Structure
REQ-032 Fetch state enum, IFQ_DEPTH default, halfword opcode typedef SHALL live in package sh1.
REQ-033 Halfword queue SHALL be sub-module sh1_ifq (data+PC FIFO, push up to 2/cycle, pop 1, flush).
REQ-034 Implementation SHALL be synthesizable, 120-400 lines total.

Verification
REQ-035 Reset, RESET_PC=0, gnt=1, rvalid 1 cycle later, rdata=32'hE101_7102, ready=1 -> instr 16'hE101 @pc 0, then 16'h7102 @pc 2, consecutive cycles.
REQ-036 Redirect to 32'h0000_0102 -> imem_addr=32'h0000_0100, only rdata[15:0] delivered, instr_pc=32'h0000_0102.
REQ-037 instr_ready=0 for 10 cycles -> at most IFQ_DEPTH entries queued, imem_req stops, instr stable; release -> all delivered in order, none lost.
REQ-038 Redirect during WAIT_RSP, rvalid 3 cycles later with 32'hDEAD_BEEF -> 16'hDEAD never appears; next instr_pc = redirect target.
REQ-039 Fetch at 32'hFFFF_FFFC -> instr_pc FFFF_FFFC, FFFF_FFFE, next imem_addr 32'h0000_0000.
REQ-040 rst_n asserted while imem_req=1 and gnt=0 -> outputs zero immediately; first request after release at RESET_PC.

Source files
------------

// File: rtl/sh1_pkg.sv
// rtl/sh1_pkg.sv - shared types and constants for the SH-1 instruction fetch unit
package sh1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DISCARD  = 2'd3
    } fetch_state_e;

    localparam int IFQ_DEPTH_DEFAULT = 4;

    typedef logic [15:0] sh1_op_t;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/sh1_ifq.sv
// rtl/sh1_ifq.sv - halfword opcode queue with per-entry PC, up to two pushes and one pop per cycle
module sh1_ifq
    import sh1::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push0_valid,
    input  sh1_op_t                  push0_data,
    input  logic [31:0]              push0_pc,
    input  logic                     push1_valid,
    input  sh1_op_t                  push1_data,
    input  logic [31:0]              push1_pc,
    input  logic                     pop,
    output logic                     out_valid,
    output sh1_op_t                  out_data,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sh1_op_t       data_q [DEPTH];
    sh1_op_t       data_d [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   pc_d   [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_next;
    logic [1:0]    n_push;
    logic          do_pop;

    always_comb begin
        data_d      = data_q;
        pc_d        = pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        wr_ptr_next = wr_ptr_q + 1'b1;
        do_pop      = pop && (count_q != '0);
        n_push      = 2'd0;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // the second slot is only meaningful alongside the first
            if (push0_valid) begin
                data_d[wr_ptr_q] = push0_data;
                pc_d[wr_ptr_q]   = push0_pc;
                n_push           = 2'd1;
                if (push1_valid) begin
                    data_d[wr_ptr_next] = push1_data;
                    pc_d[wr_ptr_next]   = push1_pc;
                    n_push              = 2'd2;
                end
            end
            wr_ptr_d = wr_ptr_q + AW'(n_push);
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(n_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? data_q[rd_ptr_q] : '0;
    assign out_pc    = out_valid ? pc_q[rd_ptr_q]   : '0;
    assign count     = count_q;

endmodule

// File: rtl/sh1_ifetch.sv
// rtl/sh1_ifetch.sv - SH-1 instruction fetch: single-outstanding word fetcher feeding a halfword queue
module sh1_ifetch
    import sh1::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IFQ_DEPTH = IFQ_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(IFQ_DEPTH) + 1;
    localparam int LW = CW + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   fetch_word;
    logic [31:0]   redirect_target;
    logic          push0_valid, push1_valid;
    sh1_op_t       push0_data, push1_data;
    logic [31:0]   push0_pc, push1_pc;
    logic          ifq_pop;
    logic [CW-1:0] ifq_count;
    logic [LW-1:0] level;
    logic          room_now;

    assign fetch_word      = word_addr(fetch_pc_q);
    assign redirect_target = redirect_pc & 32'hFFFF_FFFE;
    assign ifq_pop         = instr_valid && instr_ready;
    // a new request needs two free slots, since one word may yield two halfwords
    assign room_now        = (ifq_count <= CW'(IFQ_DEPTH - 2));

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        push0_valid = 1'b0;
        push1_valid = 1'b0;
        push0_data  = imem_rdata[15:0];
        push0_pc    = fetch_pc_q;
        push1_data  = imem_rdata[15:0];
        push1_pc    = fetch_word + 32'd2;
        level       = '0;

        if (!fetch_pc_q[1]) begin
            push0_data = imem_rdata[31:16];
            push0_pc   = fetch_word;
        end

        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_target;
                end else if (room_now) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_target;
                    // a grant in the redirect cycle still produces a response to throw away
                    state_d    = imem_gnt ? DISCARD : REQ;
                end else if (imem_gnt) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_target;
                    state_d    = imem_rvalid ? REQ : DISCARD;
                end else if (imem_rvalid) begin
                    push0_valid = 1'b1;
                    push1_valid = !fetch_pc_q[1];
                    fetch_pc_d  = fetch_word + 32'd4;
                    level       = {1'b0, ifq_count} + LW'(fetch_pc_q[1] ? 1 : 2) - LW'(ifq_pop);
                    state_d     = (level <= LW'(IFQ_DEPTH - 2)) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_target;
                end
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign imem_req  = (state_q == REQ);
    assign imem_addr = imem_req ? fetch_word : 32'h0;

    sh1_ifq #(
        .DEPTH(IFQ_DEPTH)
    ) u_ifq (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (redirect_valid),
        .push0_valid (push0_valid),
        .push0_data  (push0_data),
        .push0_pc    (push0_pc),
        .push1_valid (push1_valid),
        .push1_data  (push1_data),
        .push1_pc    (push1_pc),
        .pop         (ifq_pop),
        .out_valid   (instr_valid),
        .out_data    (instr),
        .out_pc      (instr_pc),
        .count       (ifq_count)
    );

endmodule

// File: tb/tb_sh1_ifetch.sv
// tb/tb_sh1_ifetch.sv - directed bench for sh1_ifetch with a simple latency-configurable memory
module tb_sh1_ifetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    sh1_ifetch #(
        .RESET_PC  (32'h0000_0000),
        .IFQ_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          lat;
    bit          dead_mode;
    logic [31:0] ovr_addr;
    logic [31:0] ovr_data;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_data;
    bit          last_hs;
    logic [15:0] got_i[$];
    logic [31:0] got_pc[$];

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] data;
        logic [31:0] addr;
        logic [15:0] i0;
        logic [31:0] pc0;
        logic [15:0] i1;
        logic [31:0] pc1;
    } vec_t;

    vec_t vecs[6];

    // default memory image: each halfword holds the low 16 bits of its own address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (dead_mode) return 32'hDEAD_BEEF;
        if (a == ovr_addr) return ovr_data;
        return {a[15:0], a[15:0] + 16'd2};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // called at a falling edge with inputs set; returns at the next falling edge
    task automatic cycle();
        bit          hs;
        logic [31:0] haddr;
        hs    = imem_req && imem_gnt;
        haddr = imem_addr;
        if (instr_valid && instr_ready) begin
            got_i.push_back(instr);
            got_pc.push_back(instr_pc);
        end
        @(posedge clk);
        @(negedge clk);
        last_hs     = hs;
        imem_rvalid = 1'b0;
        if (hs) begin
            pend      = 1'b1;
            pend_cnt  = lat;
            pend_data = mem_word(haddr);
        end
        if (pend) begin
            if (pend_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_data;
                pend        = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        bit          found;
        logic [31:0] e;

        rst_n = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        lat = 1; dead_mode = 1'b0; pend = 1'b0; pend_cnt = 0; pend_data = '0; last_hs = 1'b0;
        ovr_addr = 32'h0; ovr_data = 32'hE101_7102;

        vecs[0] = '{32'h0000_0102, 32'hAAAA_B0B0, 32'h0000_0100, 16'hB0B0, 32'h0000_0102, 16'h0104, 32'h0000_0104};
        vecs[1] = '{32'h0000_0200, 32'h1234_5678, 32'h0000_0200, 16'h1234, 32'h0000_0200, 16'h5678, 32'h0000_0202};
        vecs[2] = '{32'hFFFF_FFFC, 32'hCAFE_F00D, 32'hFFFF_FFFC, 16'hCAFE, 32'hFFFF_FFFC, 16'hF00D, 32'hFFFF_FFFE};
        vecs[3] = '{32'h0000_0301, 32'h5A5A_A5A5, 32'h0000_0300, 16'h5A5A, 32'h0000_0300, 16'hA5A5, 32'h0000_0302};
        vecs[4] = '{32'h0000_1006, 32'h0BAD_C0DE, 32'h0000_1004, 16'hC0DE, 32'h0000_1006, 16'h1008, 32'h0000_1008};
        vecs[5] = '{32'hFFFF_FFFE, 32'h1357_9BDF, 32'hFFFF_FFFC, 16'h9BDF, 32'hFFFF_FFFE, 16'h0000, 32'h0000_0000};

        repeat (3) @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);

        rst_n = 1'b1;
        cycle();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        cycle();
        chk("no_early_valid", instr_valid, 0);
        cycle();
        chk("hw0_valid", instr_valid, 1);
        chk("hw0_instr", instr, 16'hE101);
        chk("hw0_pc", instr_pc, 32'h0);
        cycle();
        chk("hw1_valid", instr_valid, 1);
        chk("hw1_instr", instr, 16'h7102);
        chk("hw1_pc", instr_pc, 32'h2);

        foreach (vecs[v]) begin
            instr_ready = 1'b0;
            ovr_addr    = vecs[v].addr;
            ovr_data    = vecs[v].data;
            redirect(vecs[v].rpc);
            chk($sformatf("v%0d_flushed", v), instr_valid, 0);
            for (int k = 0; k < 10 && !imem_req; k++) cycle();
            chk($sformatf("v%0d_req", v), imem_req, 1);
            chk($sformatf("v%0d_addr", v), imem_addr, vecs[v].addr);
            for (int k = 0; k < 20 && !instr_valid; k++) cycle();
            chk($sformatf("v%0d_i0", v), instr, vecs[v].i0);
            chk($sformatf("v%0d_pc0", v), instr_pc, vecs[v].pc0);
            repeat (6) cycle();
            chk($sformatf("v%0d_i0_hold", v), instr, vecs[v].i0);
            chk($sformatf("v%0d_pc0_hold", v), instr_pc, vecs[v].pc0);
            instr_ready = 1'b1;
            cycle();
            chk($sformatf("v%0d_valid1", v), instr_valid, 1);
            chk($sformatf("v%0d_i1", v), instr, vecs[v].i1);
            chk($sformatf("v%0d_pc1", v), instr_pc, vecs[v].pc1);
        end

        instr_ready = 1'b0;
        ovr_addr    = 32'h0000_0001;
        redirect(32'hFFFF_FFFC);
        for (int k = 0; k < 10 && !(imem_req && imem_addr != 32'hFFFF_FFFC); k++) cycle();
        chk("wrap_req", imem_req, 1);
        chk("wrap_addr", imem_addr, 32'h0);

        redirect(32'h0000_0400);
        repeat (10) cycle();
        chk("full_req_stopped", imem_req, 0);
        chk("full_valid", instr_valid, 1);
        chk("full_instr_hold", instr, 16'h0400);
        chk("full_pc_hold", instr_pc, 32'h400);
        got_i.delete();
        got_pc.delete();
        instr_ready = 1'b1;
        repeat (16) cycle();
        chk("drain_count", got_pc.size() >= 8, 1);
        for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
            e = 32'h400 + 32'(2 * i);
            chk($sformatf("drain_pc%0d", i), got_pc[i], e);
            chk($sformatf("drain_i%0d", i), got_i[i], {16'h0, e[15:0]});
        end

        lat       = 3;
        dead_mode = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (last_hs) break;
        end
        dead_mode = 1'b0;
        chk("dead_grant_seen", last_hs, 1);
        redirect(32'h0000_0900);
        got_i.delete();
        got_pc.delete();
        repeat (15) cycle();
        found = 1'b0;
        foreach (got_i[i]) if (got_i[i] == 16'hDEAD) found = 1'b1;
        chk("stale_dropped", found, 0);
        chk("post_redirect_count", got_pc.size() >= 1, 1);
        if (got_pc.size() > 0) begin
            chk("post_redirect_pc", got_pc[0], 32'h900);
            chk("post_redirect_instr", got_i[0], 16'h0900);
        end

        lat         = 1;
        imem_gnt    = 1'b0;
        instr_ready = 1'b0;
        redirect(32'h0000_0500);
        repeat (6) cycle();
        chk("hold_req", imem_req, 1);
        chk("hold_addr", imem_addr, 32'h500);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", imem_req, 0);
        chk("async_rst_addr", imem_addr, 0);
        chk("async_rst_valid", instr_valid, 0);
        chk("async_rst_instr", instr, 0);
        chk("async_rst_pc", instr_pc, 0);
        pend        = 1'b0;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("rerst_req", imem_req, 1);
        chk("rerst_addr", imem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
